d_ip_timer: RTL and testbench

D_IP_TIMER -- requirements
Module: d_ip_timer

---
 rtl/d_ip_timer.sv | 177 +++++++++++++++++
 tb/tb_d_ip_timer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ip_timer.sv
// Register-mapped 8-bit timer: prescaled or external tick source, TOP wrap, two compares,
// W1C interrupt flags and a timer_out waveform generator.
module d_ip_timer (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [5:0]           addr,
    input  logic                 wr_en,
    input  logic                 mod_en,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata,
    input  logic                 timer_in,
    output logic                 overflow_int,
    output logic                 comp_0_match_int,
    output logic                 comp_1_match_int,
    output logic                 timer_out
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PSC_W  = 12;
    localparam int unsigned FLG_W  = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_CNT  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_CMP0 = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_CMP1 = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_IEN  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] ADDR_IFLG = ADDR_W'(6);

    localparam logic [1:0] OM_OFF    = 2'b00;
    localparam logic [1:0] OM_TOGGLE = 2'b01;
    localparam logic [1:0] OM_PWM    = 2'b10;
    localparam logic [1:0] OM_SETCLR = 2'b11;

    typedef struct packed {
        logic [1:0] outmode;
        logic [3:0] psc;
        logic       clksel;
        logic       en;
    } ctrl_t;

    ctrl_t              r_ctrl;
    logic [DATA_W-1:0]  r_cnt;
    logic [DATA_W-1:0]  r_top;
    logic [DATA_W-1:0]  r_cmp0;
    logic [DATA_W-1:0]  r_cmp1;
    logic [FLG_W-1:0]   r_ien;
    logic [FLG_W-1:0]   r_iflg;
    logic [PSC_W-1:0]   r_psc;
    logic [1:0]         r_sync;
    logic               r_in_prev;
    logic               r_tout;

    logic               w_wr;
    logic               w_wr_cnt;
    logic [3:0]         w_psc_p;
    logic [PSC_W-1:0]   w_psc_term;
    logic               w_psc_hit;
    logic               w_edge;
    logic               w_tick;
    logic               w_wrap;
    logic [DATA_W-1:0]  w_cnt_next;
    logic               w_m0;
    logic               w_m1;
    logic [FLG_W-1:0]   w_set;
    logic [FLG_W-1:0]   w_w1c;
    logic               w_tout_next;

    assign w_wr     = mod_en & wr_en;
    assign w_wr_cnt = w_wr && (addr == ADDR_CNT);

    // Tick sources: prescaler terminal count or synchronised rising edge of timer_in
    assign w_psc_p    = (r_ctrl.psc > 4'd11) ? 4'd11 : r_ctrl.psc;
    assign w_psc_term = (PSC_W'(1) << w_psc_p) - PSC_W'(1);
    assign w_psc_hit  = r_ctrl.en & ~r_ctrl.clksel & (r_psc == w_psc_term);
    assign w_edge     = r_sync[1] & ~r_in_prev;
    // A CPU write to CNT swallows any tick in the same cycle
    assign w_tick     = r_ctrl.en & (r_ctrl.clksel ? w_edge : w_psc_hit) & ~w_wr_cnt;

    assign w_wrap     = (r_cnt == r_top);
    assign w_cnt_next = w_wrap ? '0 : r_cnt + DATA_W'(1);
    assign w_m0       = (w_cnt_next == r_cmp0) && (r_cmp0 <= r_top);
    assign w_m1       = (w_cnt_next == r_cmp1) && (r_cmp1 <= r_top);
    assign w_set      = {FLG_W{w_tick}} & {w_m1, w_m0, w_wrap};
    assign w_w1c      = (w_wr && (addr == ADDR_IFLG)) ? wdata[FLG_W-1:0] : '0;

    always_comb begin
        w_tout_next = r_tout;
        if (r_ctrl.outmode == OM_OFF) begin
            w_tout_next = 1'b0;
        end else if (w_tick) begin
            case (r_ctrl.outmode)
                OM_TOGGLE: if (w_m0) w_tout_next = ~r_tout;
                OM_PWM: begin
                    if (w_m0)
                        w_tout_next = 1'b0;
                    else if ((w_cnt_next == '0) && (r_cmp0 != '0))
                        w_tout_next = 1'b1;
                end
                OM_SETCLR: begin
                    if (w_m1)
                        w_tout_next = 1'b0;
                    else if (w_m0)
                        w_tout_next = 1'b1;
                end
                default: w_tout_next = r_tout;
            endcase
        end
    end

    // Configuration registers and flags
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ctrl <= '0;
            r_top  <= '1;
            r_cmp0 <= '0;
            r_cmp1 <= '0;
            r_ien  <= '0;
            r_iflg <= '0;
            r_tout <= 1'b0;
        end else begin
            if (w_wr && (addr == ADDR_CTRL)) r_ctrl <= ctrl_t'(wdata);
            if (w_wr && (addr == ADDR_TOP))  r_top  <= wdata;
            if (w_wr && (addr == ADDR_CMP0)) r_cmp0 <= wdata;
            if (w_wr && (addr == ADDR_CMP1)) r_cmp1 <= wdata;
            if (w_wr && (addr == ADDR_IEN))  r_ien  <= wdata[FLG_W-1:0];
            r_iflg <= (r_iflg & ~w_w1c) | w_set;
            r_tout <= w_tout_next;
        end
    end

    // Counter, prescaler and external-edge detector
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt     <= '0;
            r_psc     <= '0;
            r_sync    <= '0;
            r_in_prev <= 1'b0;
        end else begin
            if (w_wr_cnt)
                r_cnt <= wdata;
            else if (w_tick)
                r_cnt <= w_cnt_next;

            if (!r_ctrl.en || r_ctrl.clksel || w_wr_cnt || w_psc_hit)
                r_psc <= '0;
            else
                r_psc <= r_psc + PSC_W'(1);

            r_sync    <= {r_sync[0], timer_in};
            r_in_prev <= r_ctrl.en ? r_sync[1] : 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (mod_en && !wr_en) begin
            case (addr)
                ADDR_CTRL: rdata = r_ctrl;
                ADDR_CNT:  rdata = r_cnt;
                ADDR_TOP:  rdata = r_top;
                ADDR_CMP0: rdata = r_cmp0;
                ADDR_CMP1: rdata = r_cmp1;
                ADDR_IEN:  rdata = {(DATA_W-FLG_W)'(0), r_ien};
                ADDR_IFLG: rdata = {(DATA_W-FLG_W)'(0), r_iflg};
                default:   rdata = '0;
            endcase
        end
    end

    assign overflow_int     = r_iflg[0] & r_ien[0];
    assign comp_0_match_int = r_iflg[1] & r_ien[1];
    assign comp_1_match_int = r_iflg[2] & r_ien[2];
    assign timer_out        = r_tout;

endmodule

// File: tb/tb_d_ip_timer.sv
// Directed self-checking bench for d_ip_timer; every expected value is hand-computed
// from the register map and tick timing.
module tb_d_ip_timer;

    logic       clk;
    logic       rst_b;
    logic [5:0] addr;
    logic       wr_en;
    logic       mod_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       timer_in;
    logic       overflow_int;
    logic       comp_0_match_int;
    logic       comp_1_match_int;
    logic       timer_out;

    int checks   = 0;
    int failures = 0;

    d_ip_timer dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .addr             (addr),
        .wr_en            (wr_en),
        .mod_en           (mod_en),
        .wdata            (wdata),
        .rdata            (rdata),
        .timer_in         (timer_in),
        .overflow_int     (overflow_int),
        .comp_0_match_int (comp_0_match_int),
        .comp_1_match_int (comp_1_match_int),
        .timer_out        (timer_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Drive at a falling edge, write lands on the following rising edge, return at next falling edge
    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1; mod_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; mod_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        addr = a; wr_en = 1'b0; mod_en = 1'b1;
        #1;
        d = rdata;
        mod_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] exp_rst [7];
        exp_rst = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        rst_b = 1'b0; addr = '0; wdata = '0; wr_en = 1'b0; mod_en = 1'b0; timer_in = 1'b0;
        #12;
        rd(6'h02, v);
        checks++;
        if (v !== 8'hFF) begin
            failures++; $display("FAIL reset_top_in_reset: got %02h want FF", v);
        end
        checks++;
        if ({overflow_int, comp_0_match_int, comp_1_match_int, timer_out} !== 4'b0000) begin
            failures++; $display("FAIL reset_outputs: got %b want 0000",
                {overflow_int, comp_0_match_int, comp_1_match_int, timer_out});
        end
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rd(6'(i), v);
            checks++;
            if (v !== exp_rst[i]) begin
                failures++; $display("FAIL reset_reg_%0d: got %02h want %02h", i, v, exp_rst[i]);
            end
        end
        rd(6'h07, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("FAIL unmapped_07: got %02h want 00", v);
        end
        rd(6'h3F, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("FAIL unmapped_3f: got %02h want 00", v);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        wr(6'h02, 8'h09);
        wr(6'h05, 8'h01);
        wr(6'h00, 8'h01);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            rd(6'h01, v);
            checks++;
            if (v !== 8'(i % 10)) begin
                failures++; $display("FAIL ovf_cnt_step%0d: got %02h want %02h", i, v, 8'(i % 10));
            end
            if (i == 9) begin
                checks++;
                if (overflow_int !== 1'b0) begin
                    failures++; $display("FAIL ovf_int_early: got %b want 0", overflow_int);
                end
            end
        end
        checks++;
        if (overflow_int !== 1'b1) begin
            failures++; $display("FAIL ovf_int_on_wrap: got %b want 1", overflow_int);
        end
        // CMP0=CMP1=0 also match on the wrap tick, so all three flags set together
        rd(6'h06, v);
        checks++;
        if (v !== 8'h07) begin
            failures++; $display("FAIL ovf_iflg_all: got %02h want 07", v);
        end
        wr(6'h06, 8'h01);
        checks++;
        if (overflow_int !== 1'b0) begin
            failures++; $display("FAIL ovf_int_w1c: got %b want 0", overflow_int);
        end
        rd(6'h06, v);
        checks++;
        if (v !== 8'h06) begin
            failures++; $display("FAIL ovf_iflg_after_w1c: got %02h want 06", v);
        end
        // Disable lands two ticks later (CNT=4); the counter must then hold
        wr(6'h00, 8'h00);
        repeat (5) @(negedge clk);
        rd(6'h01, v);
        checks++;
        if (v !== 8'h04) begin
            failures++; $display("FAIL en0_hold_cnt: got %02h want 04", v);
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] v;
        wr(6'h01, 8'h00);
        wr(6'h02, 8'hFF);
        wr(6'h06, 8'h07);
        wr(6'h00, 8'h0D);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            rd(6'h01, v);
            checks++;
            if (v !== 8'(i / 8)) begin
                failures++; $display("FAIL psc3_cycle%0d: got %02h want %02h", i, v, 8'(i / 8));
            end
        end
        wr(6'h00, 8'h00);
    endtask

    task automatic test_external();
        logic [7:0] v;
        wr(6'h01, 8'h00);
        wr(6'h06, 8'h07);
        wr(6'h00, 8'h03);
        repeat (3) @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            timer_in = 1'b1;
            if (p == 0) begin
                repeat (3) @(posedge clk);
                #1;
                rd(6'h01, v);
                checks++;
                if (v !== 8'h01) begin
                    failures++; $display("FAIL ext_latency: got %02h want 01", v);
                end
            end
            repeat (25) @(negedge clk);
            rd(6'h01, v);
            checks++;
            if (v !== 8'(p + 1)) begin
                failures++; $display("FAIL ext_pulse%0d: got %02h want %02h", p, v, 8'(p + 1));
            end
            timer_in = 1'b0;
            repeat (25) @(negedge clk);
        end
        rd(6'h01, v);
        checks++;
        if (v !== 8'h05) begin
            failures++; $display("FAIL ext_final: got %02h want 05", v);
        end
        wr(6'h00, 8'h00);
    endtask

    task automatic test_pwm();
        logic e;
        wr(6'h01, 8'h00);
        wr(6'h02, 8'h09);
        wr(6'h03, 8'h03);
        wr(6'h06, 8'h07);
        wr(6'h00, 8'h81);
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            e = (i >= 10) && ((i % 10) < 3);
            checks++;
            if (timer_out !== e) begin
                failures++; $display("FAIL pwm_cycle%0d: got %b want %b", i, timer_out, e);
            end
        end
        wr(6'h00, 8'h00);
    endtask

    task automatic test_cmp1_w1c();
        logic [7:0] v;
        wr(6'h01, 8'h00);
        wr(6'h02, 8'hFF);
        wr(6'h04, 8'h04);
        wr(6'h05, 8'h04);
        wr(6'h06, 8'h07);
        wr(6'h00, 8'h01);
        // Place the W1C on the same rising edge where CNT becomes 4
        repeat (2) @(negedge clk);
        wr(6'h06, 8'h04);
        checks++;
        if (comp_1_match_int !== 1'b1) begin
            failures++; $display("FAIL cmp1_set_wins_int: got %b want 1", comp_1_match_int);
        end
        rd(6'h06, v);
        checks++;
        if (v !== 8'h06) begin
            failures++; $display("FAIL cmp1_set_wins_iflg: got %02h want 06", v);
        end
        wr(6'h06, 8'h04);
        checks++;
        if (comp_1_match_int !== 1'b0) begin
            failures++; $display("FAIL cmp1_w1c_clear: got %b want 0", comp_1_match_int);
        end
        rd(6'h01, v);
        checks++;
        if (v !== 8'h06) begin
            failures++; $display("FAIL cmp1_cnt: got %02h want 06", v);
        end
        rd(6'h06, v);
        checks++;
        if (v !== 8'h02) begin
            failures++; $display("FAIL cmp1_iflg_after: got %02h want 02", v);
        end
    endtask

    task automatic test_cnt_write();
        logic [7:0] v;
        wr(6'h06, 8'h07);
        // Writing CMP0's value to CNT must not raise the CMP0 flag
        wr(6'h01, 8'h03);
        rd(6'h01, v);
        checks++;
        if (v !== 8'h03) begin
            failures++; $display("FAIL cntwr_value: got %02h want 03", v);
        end
        rd(6'h06, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("FAIL cntwr_no_flag: got %02h want 00", v);
        end
        @(negedge clk);
        rd(6'h01, v);
        checks++;
        if (v !== 8'h04) begin
            failures++; $display("FAIL cntwr_resume: got %02h want 04", v);
        end
        rd(6'h06, v);
        checks++;
        if (v !== 8'h04) begin
            failures++; $display("FAIL cntwr_cmp1_after: got %02h want 04", v);
        end
    endtask

    task automatic test_reset_midcount();
        logic [7:0] v;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        rd(6'h01, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("FAIL midrst_cnt: got %02h want 00", v);
        end
        checks++;
        if (comp_1_match_int !== 1'b0) begin
            failures++; $display("FAIL midrst_int: got %b want 0", comp_1_match_int);
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        rd(6'h01, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("FAIL midrst_no_resume: got %02h want 00", v);
        end
        rd(6'h00, v);
        checks++;
        if (v !== 8'h00) begin
            failures++; $display("FAIL midrst_ctrl: got %02h want 00", v);
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_prescaler();
        test_external();
        test_pwm();
        test_cmp1_w1c();
        test_cnt_write();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
